gol_engine: RTL and testbench

- Parametrised Game-of-Life generation engine; successor to the single-size, single-mode update logic.
- Holds the live grid, accepts a bulk load, and advances one generation per `step` request.
- Evaluates one row per cycle against a frozen snapshot, then commits atomically.
- Adds selectable toroidal/dead-edge boundary, a busy/done handshake, a generation counter, a live-cell count and stable-pattern detection for the display/control path.

---
 rtl/gol_pkg.sv | 29 ++
 rtl/gol_row_eval.sv | 40 ++++
 rtl/gol_engine.sv | 142 ++++++++++++++
 tb/tb_gol_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life generation engine.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int WRAP_DEAD  = 0;
  localparam int WRAP_TORUS = 1;

  // Widest row the popcount helper handles; wider grids need this raised.
  localparam int POP_W = 64;

  // Life rule: survive on 2 or 3 neighbours, birth on exactly 3.
  function automatic logic next_cell(input logic alive, input logic [3:0] n);
    return alive ? ((n == 4'd2) || (n == 4'd3)) : (n == 4'd3);
  endfunction

  // Count of set bits in a (zero-extended) row.
  function automatic logic [6:0] popcount(input logic [POP_W-1:0] row);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_W; i++) cnt = cnt + {6'd0, row[i]};
    return cnt;
  endfunction

endpackage

// File: rtl/gol_row_eval.sv
// Combinational evaluation of one grid row from its two neighbouring rows.
// Column wrap / dead-edge handling is resolved per column at elaboration time.
module gol_row_eval
  import gol_pkg::*;
#(
  parameter int COLS = 16,
  parameter int WRAP = 0
) (
  input  logic [COLS-1:0] i_above,
  input  logic [COLS-1:0] i_cur,
  input  logic [COLS-1:0] i_below,
  output logic [COLS-1:0] o_next
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int CL = (c == 0) ? COLS - 1 : c - 1;
    localparam int CR = (c == COLS - 1) ? 0 : c + 1;
    // A neighbour column exists unless it falls off a dead edge.
    localparam bit LV = (c != 0) || (WRAP == WRAP_TORUS);
    localparam bit RV = (c != COLS - 1) || (WRAP == WRAP_TORUS);

    logic       w_al, w_ar, w_cl, w_cr, w_bl, w_br;
    logic [3:0] w_n;

    assign w_al = LV & i_above[CL];
    assign w_ar = RV & i_above[CR];
    assign w_cl = LV & i_cur[CL];
    assign w_cr = RV & i_cur[CR];
    assign w_bl = LV & i_below[CL];
    assign w_br = RV & i_below[CR];

    // Four-bit sum so a fully surrounded cell reads 8, not 0.
    assign w_n = {3'd0, w_al} + {3'd0, i_above[c]} + {3'd0, w_ar}
               + {3'd0, w_cl} + {3'd0, w_cr}
               + {3'd0, w_bl} + {3'd0, i_below[c]} + {3'd0, w_br};

    assign o_next[c] = next_cell(i_cur[c], w_n);
  end

endmodule

// File: rtl/gol_engine.sv
// Game-of-Life generation engine: one row per cycle against the frozen grid,
// then an atomic commit of the whole next generation.
module gol_engine
  import gol_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [ROWS-1:0][COLS-1:0]      load_grid,
  input  logic                           step,
  output logic [ROWS-1:0][COLS-1:0]      grid,
  output logic                           busy,
  output logic                           done,
  output logic [GEN_W-1:0]               gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0] alive_count,
  output logic                           stable
);

  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(ROWS*COLS+1);

  state_t                   r_state, w_state_nxt;
  logic [ROWS-1:0][COLS-1:0] r_grid, r_next;
  logic [RW-1:0]            r_row;
  logic [AW-1:0]            r_acc, r_alive;
  logic [GEN_W-1:0]         r_gen;
  logic                     r_diff, r_busy, r_done, r_stable;

  logic [COLS-1:0]          w_above, w_cur, w_below, w_next_row;
  logic [AW-1:0]            w_load_pop;
  logic                     w_last_row;

  assign w_last_row = (r_row == RW'(ROWS - 1));

  // Neighbour row selection with row wrap or dead edge.
  always_comb begin
    w_cur = r_grid[r_row];
    if (r_row == '0)
      w_above = (WRAP == WRAP_TORUS) ? r_grid[ROWS-1] : '0;
    else
      w_above = r_grid[r_row - RW'(1)];
    if (w_last_row)
      w_below = (WRAP == WRAP_TORUS) ? r_grid[0] : '0;
    else
      w_below = r_grid[r_row + RW'(1)];
  end

  gol_row_eval #(
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_row_eval (
    .i_above (w_above),
    .i_cur   (w_cur),
    .i_below (w_below),
    .o_next  (w_next_row)
  );

  // Live-cell count of an incoming load pattern.
  always_comb begin
    w_load_pop = '0;
    for (int r = 0; r < ROWS; r++)
      w_load_pop = w_load_pop + AW'(popcount(POP_W'(load_grid[r])));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; load takes priority over step in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!load && step) w_state_nxt = CALC;
      CALC:    if (w_last_row)    w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grid, next buffer, accumulator and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grid   <= '0;
      r_next   <= '0;
      r_row    <= '0;
      r_acc    <= '0;
      r_alive  <= '0;
      r_gen    <= '0;
      r_diff   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_grid   <= load_grid;
            r_gen    <= '0;
            r_alive  <= w_load_pop;
            r_stable <= 1'b0;
          end else if (step) begin
            r_row  <= '0;
            r_acc  <= '0;
            r_diff <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        CALC: begin
          r_next[r_row] <= w_next_row;
          r_acc         <= r_acc + AW'(popcount(POP_W'(w_next_row)));
          r_diff        <= r_diff | (w_next_row != r_grid[r_row]);
          if (!w_last_row) r_row <= r_row + RW'(1);
        end
        COMMIT: begin
          r_grid   <= r_next;
          r_alive  <= r_acc;
          r_stable <= ~r_diff;
          r_gen    <= r_gen + GEN_W'(1);
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grid        = r_grid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign gen_count   = r_gen;
  assign alive_count = r_alive;
  assign stable      = r_stable;

endmodule

// File: tb/tb_gol_engine.sv
// Directed bench: a dead-edge and a toroidal engine share stimulus; a
// reference Life model pushes expected generations that are popped on done.
module tb_gol_engine;

  typedef logic [15:0][15:0] grid_t;
  typedef struct {
    grid_t g;
    int    alive;
    int    gen;
    bit    stable;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  load, step;
  grid_t load_grid;

  grid_t      o_grid  [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  logic [15:0] o_gen  [2];
  logic [8:0] o_alive [2];
  logic       o_stable[2];

  int    checks = 0;
  int    errors = 0;
  exp_t  q_dead[$];
  exp_t  q_torus[$];
  grid_t m_grid[2];
  int    m_gen[2];

  always #5 clk = ~clk;

  gol_engine #(.ROWS(16), .COLS(16), .WRAP(0), .GEN_W(16)) u_dead (
    .clk(clk), .reset(reset), .load(load), .load_grid(load_grid), .step(step),
    .grid(o_grid[0]), .busy(o_busy[0]), .done(o_done[0]), .gen_count(o_gen[0]),
    .alive_count(o_alive[0]), .stable(o_stable[0])
  );

  gol_engine #(.ROWS(16), .COLS(16), .WRAP(1), .GEN_W(16)) u_torus (
    .clk(clk), .reset(reset), .load(load), .load_grid(load_grid), .step(step),
    .grid(o_grid[1]), .busy(o_busy[1]), .done(o_done[1]), .gen_count(o_gen[1]),
    .alive_count(o_alive[1]), .stable(o_stable[1])
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pop(input grid_t g);
    int n = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (g[r][c]) n++;
    return n;
  endfunction

  function automatic grid_t life(input grid_t g, input bit wrap);
    grid_t o = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wrap) begin
              rr = (rr + 16) % 16;
              cc = (cc + 16) % 16;
            end else if (rr < 0 || rr > 15 || cc < 0 || cc > 15) begin
              continue;
            end
            if (g[rr][cc]) n++;
          end
        end
        o[r][c] = g[r][c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return o;
  endfunction

  task automatic chk_model(input string tag);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("%s.grid[%0d]", tag, w),  256'(o_grid[w]),  256'(m_grid[w]));
      chk($sformatf("%s.alive[%0d]", tag, w), 256'(o_alive[w]), 256'(pop(m_grid[w])));
      chk($sformatf("%s.gen[%0d]", tag, w),   256'(o_gen[w]),   256'(m_gen[w]));
    end
  endtask

  task automatic do_load(input grid_t p, input string tag);
    @(negedge clk);
    load = 1'b1;
    load_grid = p;
    @(negedge clk);
    load = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_grid[w] = p;
      m_gen[w]  = 0;
      chk($sformatf("%s.stable[%0d]", tag, w), 256'(o_stable[w]), 256'(0));
    end
    chk_model(tag);
  endtask

  // One generation; optionally pokes step/load while the engine is busy.
  task automatic do_step(input string tag, input bit poke_step, input bit poke_load,
                         input grid_t poke_grid);
    exp_t e;
    int   cyc;
    int   extra;
    @(negedge clk);
    step = 1'b1;
    for (int w = 0; w < 2; w++) begin
      e.g      = life(m_grid[w], w == 1);
      e.alive  = pop(e.g);
      e.gen    = (m_gen[w] + 1) % 65536;
      e.stable = (e.g == m_grid[w]);
      if (w == 0) q_dead.push_back(e);
      else        q_torus.push_back(e);
    end
    @(negedge clk);
    step = 1'b0;
    for (int w = 0; w < 2; w++)
      chk($sformatf("%s.busy_hi[%0d]", tag, w), 256'(o_busy[w]), 256'(1));
    cyc = 0;
    while (!o_done[0] && cyc < 40) begin
      if (cyc == 2 && (poke_step || poke_load)) begin
        step = poke_step;
        load = poke_load;
        load_grid = poke_grid;
      end else begin
        step = 1'b0;
        load = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    step = 1'b0;
    load = 1'b0;
    chk({tag, ".latency"}, 256'(cyc), 256'(17));
    for (int w = 0; w < 2; w++) begin
      if (w == 0) e = q_dead.pop_front();
      else        e = q_torus.pop_front();
      chk($sformatf("%s.done[%0d]", tag, w),   256'(o_done[w]),   256'(1));
      chk($sformatf("%s.grid[%0d]", tag, w),   256'(o_grid[w]),   256'(e.g));
      chk($sformatf("%s.alive[%0d]", tag, w),  256'(o_alive[w]),  256'(e.alive));
      chk($sformatf("%s.gen[%0d]", tag, w),    256'(o_gen[w]),    256'(e.gen));
      chk($sformatf("%s.stable[%0d]", tag, w), 256'(o_stable[w]), 256'(e.stable));
      chk($sformatf("%s.busy_lo[%0d]", tag, w), 256'(o_busy[w]),  256'(0));
      m_grid[w] = e.g;
      m_gen[w]  = e.gen;
    end
    @(negedge clk);
    for (int w = 0; w < 2; w++)
      chk($sformatf("%s.done_pulse[%0d]", tag, w), 256'(o_done[w]), 256'(0));
    if (poke_step || poke_load) begin
      extra = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (o_done[0] || o_done[1] || o_busy[0]) extra++;
      end
      chk({tag, ".no_extra_gen"}, 256'(extra), 256'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    grid_t p, blinker, corners, corners4, glider;
    int    dn;

    reset = 1'b0;
    load = 1'b0;
    step = 1'b0;
    load_grid = '0;
    for (int w = 0; w < 2; w++) begin
      m_grid[w] = '0;
      m_gen[w]  = 0;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("rst.grid[%0d]", w),   256'(o_grid[w]),   256'(0));
      chk($sformatf("rst.gen[%0d]", w),    256'(o_gen[w]),    256'(0));
      chk($sformatf("rst.alive[%0d]", w),  256'(o_alive[w]),  256'(0));
      chk($sformatf("rst.busy[%0d]", w),   256'(o_busy[w]),   256'(0));
      chk($sformatf("rst.done[%0d]", w),   256'(o_done[w]),   256'(0));
      chk($sformatf("rst.stable[%0d]", w), 256'(o_stable[w]), 256'(0));
    end
    reset = 1'b1;

    // Blinker oscillates with period 2.
    blinker = '0;
    blinker[7][6] = 1'b1;
    blinker[7][7] = 1'b1;
    blinker[7][8] = 1'b1;
    do_load(blinker, "blink_load");
    do_step("blink1", 1'b0, 1'b0, '0);
    p = '0;
    p[6][7] = 1'b1;
    p[7][7] = 1'b1;
    p[8][7] = 1'b1;
    chk("blink1.vertical", 256'(o_grid[0]), 256'(p));
    do_step("blink2", 1'b0, 1'b0, '0);
    chk("blink2.restored", 256'(o_grid[0]), 256'(blinker));

    // Corners: block across the torus seam; isolated cells die at dead edges.
    corners = '0;
    corners[0][0]  = 1'b1;
    corners[0][15] = 1'b1;
    corners[15][0] = 1'b1;
    corners4 = corners;
    corners4[15][15] = 1'b1;
    do_load(corners, "corner_load");
    do_step("corner1", 1'b0, 1'b0, '0);
    chk("corner1.torus_grid", 256'(o_grid[1]),  256'(corners4));
    chk("corner1.torus_alive", 256'(o_alive[1]), 256'(4));
    chk("corner1.dead_grid", 256'(o_grid[0]),   256'(0));
    do_step("corner2", 1'b0, 1'b0, '0);
    chk("corner2.torus_stable", 256'(o_stable[1]), 256'(1));
    chk("corner2.torus_grid", 256'(o_grid[1]), 256'(corners4));

    // All ones: every torus cell sees 8 neighbours and dies.
    p = '1;
    do_load(p, "ones_load");
    do_step("ones1", 1'b0, 1'b0, '0);
    chk("ones1.torus_grid", 256'(o_grid[1]), 256'(0));
    chk("ones1.torus_alive", 256'(o_alive[1]), 256'(0));

    // Glider returns home on a 16x16 torus after 64 generations.
    glider = '0;
    glider[0][1] = 1'b1;
    glider[1][2] = 1'b1;
    glider[2][0] = 1'b1;
    glider[2][1] = 1'b1;
    glider[2][2] = 1'b1;
    do_load(glider, "glider_load");
    for (int i = 0; i < 64; i++) begin
      do_step($sformatf("glider%0d", i), 1'b0, 1'b0, '0);
      chk($sformatf("glider%0d.torus_alive5", i), 256'(o_alive[1]), 256'(5));
    end
    chk("glider.home", 256'(o_grid[1]), 256'(glider));
    chk("glider.gen64", 256'(o_gen[1]), 256'(64));

    // Step while busy is dropped; load while busy is ignored.
    do_load(blinker, "hs_load");
    do_step("hs_step_busy", 1'b1, 1'b0, '0);
    chk("hs_step_busy.gen1", 256'(o_gen[0]), 256'(1));
    p = '1;
    do_step("hs_load_busy", 1'b0, 1'b1, p);
    chk("hs_load_busy.gen2", 256'(o_gen[0]), 256'(2));

    // Load and step together: load wins.
    corners = glider;
    @(negedge clk);
    load = 1'b1;
    step = 1'b1;
    load_grid = corners;
    @(negedge clk);
    load = 1'b0;
    step = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_grid[w] = corners;
      m_gen[w]  = 0;
      chk($sformatf("ls.busy[%0d]", w), 256'(o_busy[w]), 256'(0));
    end
    chk_model("ls");
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (o_done[0] || o_busy[0]) dn++;
    end
    chk("ls.no_gen", 256'(dn), 256'(0));

    // Reset in the middle of a generation discards it.
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("mrst.grid[%0d]", w),  256'(o_grid[w]),  256'(0));
      chk($sformatf("mrst.busy[%0d]", w),  256'(o_busy[w]),  256'(0));
      chk($sformatf("mrst.gen[%0d]", w),   256'(o_gen[w]),   256'(0));
      chk($sformatf("mrst.alive[%0d]", w), 256'(o_alive[w]), 256'(0));
      m_grid[w] = '0;
      m_gen[w]  = 0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_done[0] || o_done[1]) dn++;
    end
    chk("mrst.no_done", 256'(dn), 256'(0));
    do_load(blinker, "post_rst_load");
    do_step("post_rst", 1'b0, 1'b0, '0);
    chk("post_rst.gen1", 256'(o_gen[0]), 256'(1));

    chk("sb.empty", 256'(q_dead.size() + q_torus.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
